lsu_cache_requester: RTL and testbench
======================================

Name: lsu_cache_requester

Overview:
- CPU-side initiator for the cache request protocol, placed between a core's load/store stage and the ICACHE/DCACHE request port.
- Accepts one core memory operation at a time: LOAD, STORE or CLFLUSH, sized BYTE, HALF or WORD.
- Checks alignment, lane-shifts store data, issues the request to the cache and waits for completion.
- Extracts and sign/zero-extends load data and returns a single response to the core, with a timeout watchdog.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; fixed at 32 (4 byte lanes).
- TIMEOUT_CYCLES, 64, max cycles in WAIT before an error response; must be ≥ 2.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset_n  in  1  synchronous active-low reset.
- core_req_valid  in  1  core request valid.
- core_req_ready  out  1  block can accept a core request.
- core_req_op  in  2  memory_operation_e: STORE=00, LOAD=01, CLFLUSH=11.
- core_req_size  in  2  memory_operation_size_e: BYTE=00, HALF=01, WORD=10.
- core_req_unsigned  in  1  zero-extend load result when 1.
- core_req_addr  in  ADDR_W  byte address.
- core_req_wdata  in  DATA_W  store data, right-justified.
- cache_req_valid  out  1  request valid toward cache.
- cache_req_ready  in  1  cache accepts the request.
- cache_req_op  out  2  registered op.
- cache_req_size  out  2  registered size.
- cache_req_addr  out  ADDR_W  registered address, unmodified.
- cache_req_wdata  out  DATA_W  store data shifted into its byte lanes.
- cache_req_wstrb  out  4  byte-lane enables; stores only, 0 otherwise.
- cache_rsp_valid  in  1  one-cycle completion pulse from cache.
- cache_rsp_rdata  in  DATA_W  full aligned word containing the addressed bytes.
- core_rsp_valid  out  1  one-cycle response pulse to core.
- core_rsp_rdata  out  DATA_W  extended load data; 0 for STORE, CLFLUSH and errors.
- core_rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal op/size.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESPOND.
- Reset (reset_n=0 at a clk edge):
  - state←IDLE; core_req_ready=1.
  - cache_req_valid=0, core_rsp_valid=0, core_rsp_rdata=0, core_rsp_err=00, cache_req_wstrb=0.
  - Registered cache_req_* fields←0.
  - Reset in any state abandons the transaction. No response is produced. A later cache_rsp_valid for the abandoned request is ignored in IDLE.
- core_req_ready=1 only in IDLE.
- Accept: core_req_valid & core_req_ready at the edge. All request fields are registered in that same edge.
- Legality checks at accept:
  - Illegal: size=11, op=10, or any X/Z bit on op.
  - Misaligned: HALF with addr[0]=1, or WORD with addr[1:0]≠00. CLFLUSH ignores size and alignment.
  - Illegal or misaligned → go to RESPOND with err 11 or 01. The cache is never requested.
  - Otherwise → go to ISSUE.
- Lane shift for STORE (shift = addr[1:0]×8):
  - BYTE: wdata[7:0]<<shift; wstrb = 0001<<addr[1:0].
  - HALF: wdata[15:0]<<shift; wstrb = 0011<<addr[1:0].
  - WORD: wdata as-is; wstrb = 1111.
  - LOAD and CLFLUSH: wdata=0, wstrb=0.
- ISSUE:
  - cache_req_valid=1; fields stable until handshake.
  - On cache_req_ready=1 → WAIT; cache_req_valid drops the next cycle.
  - Timeout counter cleared on entry to ISSUE; counts in ISSUE and WAIT.
- WAIT:
  - cache_rsp_valid=1 → capture and extend read data → RESPOND.
  - Counter reaching TIMEOUT_CYCLES with no response → RESPOND, err=10, rdata=0.
  - cache_rsp_valid in the same cycle as the handshake is not possible by protocol. If it occurs, it is ignored.
- Load extraction: byte/half selected by addr[1:0] from cache_rsp_rdata. Sign-extend unless core_req_unsigned. WORD passes through.
- RESPOND:
  - core_rsp_valid=1 for exactly one cycle with rdata/err → IDLE.
  - No back-pressure from the core.
- Latency (ready cache, response N cycles after handshake): accept edge → ISSUE; handshake; response; RESPOND. core_rsp_valid rises N+2 cycles after accept. Error paths respond 1 cycle after accept.
- Back-to-back: a new request may be accepted the cycle after RESPOND, when IDLE is re-entered.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles mid-WAIT → all outputs at reset values; core_req_ready=1; a stray cache_rsp_valid next cycle produces no core_rsp_valid.
- Byte store: STORE BYTE addr=0x1003 wdata=0xA5 → cache_req_wdata=0xA5000000, wstrb=1000; cache_rsp_valid → core_rsp_valid, err=00, rdata=0.
- Signed half load: LOAD HALF addr=0x2002, cache_rsp_rdata=0x8001FFFF → rdata=0xFFFF8001; same with unsigned=1 → 0x00008001.
- Misaligned: LOAD WORD addr=0x3001 → cache_req_valid never asserted; core_rsp_valid 1 cycle after accept, err=01.
- Back-pressure and timeout: CLFLUSH with cache_req_ready low for 5 cycles → fields stable, wstrb=0; after handshake no response → err=10 exactly TIMEOUT_CYCLES=64 cycles after ISSUE entry.
- Illegal op: op=10 → err=11, rdata=0; a back-to-back legal WORD LOAD is accepted the next IDLE cycle.

Source files
------------

// File: rtl/lsu_cache_requester.sv
`default_nettype none
// ============================================================================
// Module   : lsu_cache_requester
// Brief    : Single-outstanding LOAD/STORE/CLFLUSH requester between a core
//            load/store stage and a cache request port, with timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_cache_requester #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic [1:0]        core_req_op,
    input  logic [1:0]        core_req_size,
    input  logic              core_req_unsigned,
    input  logic [ADDR_W-1:0] core_req_addr,
    input  logic [DATA_W-1:0] core_req_wdata,
    output logic              cache_req_valid,
    input  logic              cache_req_ready,
    output logic [1:0]        cache_req_op,
    output logic [1:0]        cache_req_size,
    output logic [ADDR_W-1:0] cache_req_addr,
    output logic [DATA_W-1:0] cache_req_wdata,
    output logic [3:0]        cache_req_wstrb,
    input  logic              cache_rsp_valid,
    input  logic [DATA_W-1:0] cache_rsp_rdata,
    output logic              core_rsp_valid,
    output logic [DATA_W-1:0] core_rsp_rdata,
    output logic [1:0]        core_rsp_err
);

    localparam logic [1:0] c_op_store    = 2'b00;
    localparam logic [1:0] c_op_load     = 2'b01;
    localparam logic [1:0] c_op_clflush  = 2'b11;
    localparam logic [1:0] c_sz_byte     = 2'b00;
    localparam logic [1:0] c_sz_half     = 2'b01;
    localparam logic [1:0] c_sz_word     = 2'b10;
    localparam logic [1:0] c_err_ok      = 2'b00;
    localparam logic [1:0] c_err_misalgn = 2'b01;
    localparam logic [1:0] c_err_timeout = 2'b10;
    localparam logic [1:0] c_err_illegal = 2'b11;

    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          op_q, size_q, err_q;
    logic                unsigned_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [3:0]          wstrb_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                w_illegal, w_misalign, w_timeout;
    logic [1:0]          w_err;
    logic [4:0]          w_shift;
    logic [DATA_W-1:0]   w_wdata, w_rsp_lane, w_load_data;
    logic [3:0]          w_wstrb;

    // Unknown op bits fall through to default and are treated as illegal.
    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        case (core_req_op)
            c_op_store, c_op_load: begin
                case (core_req_size)
                    c_sz_byte: w_misalign = 1'b0;
                    c_sz_half: w_misalign = core_req_addr[0];
                    c_sz_word: w_misalign = |core_req_addr[1:0];
                    default:   w_illegal  = 1'b1;
                endcase
            end
            c_op_clflush: w_illegal = 1'b0;
            default:      w_illegal = 1'b1;
        endcase
    end

    assign w_err   = w_illegal  ? c_err_illegal :
                     w_misalign ? c_err_misalgn : c_err_ok;
    assign w_shift = {core_req_addr[1:0], 3'b000};

    always_comb begin
        w_wdata = '0;
        w_wstrb = '0;
        if (core_req_op == c_op_store) begin
            case (core_req_size)
                c_sz_byte: begin
                    w_wdata = DATA_W'(core_req_wdata[7:0]) << w_shift;
                    w_wstrb = 4'b0001 << core_req_addr[1:0];
                end
                c_sz_half: begin
                    w_wdata = DATA_W'(core_req_wdata[15:0]) << w_shift;
                    w_wstrb = 4'b0011 << core_req_addr[1:0];
                end
                c_sz_word: begin
                    w_wdata = core_req_wdata;
                    w_wstrb = 4'b1111;
                end
                default: ;
            endcase
        end
    end

    // Word accesses are aligned, so the lane-shifted word equals the raw word.
    always_comb begin
        w_rsp_lane  = cache_rsp_rdata >> {addr_q[1:0], 3'b000};
        w_load_data = '0;
        if (op_q == c_op_load) begin
            case (size_q)
                c_sz_byte: w_load_data = {{(DATA_W-8){~unsigned_q & w_rsp_lane[7]}},
                                          w_rsp_lane[7:0]};
                c_sz_half: w_load_data = {{(DATA_W-16){~unsigned_q & w_rsp_lane[15]}},
                                          w_rsp_lane[15:0]};
                default:   w_load_data = w_rsp_lane;
            endcase
        end
    end

    assign w_timeout = (cnt_q >= c_cnt_last);

    always_comb begin
        state_d         = state_q;
        core_req_ready  = 1'b0;
        cache_req_valid = 1'b0;
        core_rsp_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                core_req_ready = 1'b1;
                if (core_req_valid) begin
                    state_d = (w_illegal || w_misalign) ? S_RESPOND : S_ISSUE;
                end
            end
            S_ISSUE: begin
                cache_req_valid = 1'b1;
                if (cache_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cache_rsp_valid || w_timeout) state_d = S_RESPOND;
            end
            S_RESPOND: begin
                core_rsp_valid = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            err_q      <= c_err_ok;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (core_req_valid) begin
                        op_q       <= core_req_op;
                        size_q     <= core_req_size;
                        unsigned_q <= core_req_unsigned;
                        addr_q     <= core_req_addr;
                        wdata_q    <= w_wdata;
                        wstrb_q    <= w_wstrb;
                        rdata_q    <= '0;
                        err_q      <= w_err;
                        cnt_q      <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!w_timeout) cnt_q <= cnt_q + 1'b1;
                end
                S_WAIT: begin
                    if (!w_timeout) cnt_q <= cnt_q + 1'b1;
                    // A response arriving on the timeout edge still wins.
                    if (cache_rsp_valid) begin
                        rdata_q <= w_load_data;
                    end else if (w_timeout) begin
                        rdata_q <= '0;
                        err_q   <= c_err_timeout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cache_req_op    = op_q;
    assign cache_req_size  = size_q;
    assign cache_req_addr  = addr_q;
    assign cache_req_wdata = wdata_q;
    assign cache_req_wstrb = wstrb_q;
    assign core_rsp_rdata  = rdata_q;
    assign core_rsp_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_cache_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_cache_requester
// Brief    : Self-checking bench: vector table, randomized traffic against a
//            byte-level reference model, and reset / timeout sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_cache_requester;

    localparam int TO = 64;
    localparam logic [1:0] ST = 2'b00, LD = 2'b01, FL = 2'b11, BAD = 2'b10;
    localparam logic [1:0] BY = 2'b00, HF = 2'b01, WD = 2'b10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        core_req_valid, core_req_ready, core_req_unsigned;
    logic [1:0]  core_req_op, core_req_size;
    logic [31:0] core_req_addr, core_req_wdata;
    logic        cache_req_valid, cache_req_ready;
    logic [1:0]  cache_req_op, cache_req_size;
    logic [31:0] cache_req_addr, cache_req_wdata;
    logic [3:0]  cache_req_wstrb;
    logic        cache_rsp_valid;
    logic [31:0] cache_rsp_rdata;
    logic        core_rsp_valid;
    logic [31:0] core_rsp_rdata;
    logic [1:0]  core_rsp_err;

    int total = 0;
    int bad   = 0;

    lsu_cache_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_op(core_req_op), .core_req_size(core_req_size),
        .core_req_unsigned(core_req_unsigned), .core_req_addr(core_req_addr),
        .core_req_wdata(core_req_wdata),
        .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
        .cache_req_op(cache_req_op), .cache_req_size(cache_req_size),
        .cache_req_addr(cache_req_addr), .cache_req_wdata(cache_req_wdata),
        .cache_req_wstrb(cache_req_wstrb),
        .cache_rsp_valid(cache_rsp_valid), .cache_rsp_rdata(cache_rsp_rdata),
        .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
        .core_rsp_err(core_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
        int          rdy;
        int          dly;
        logic [1:0]  e_err;
        logic [31:0] e_rdata;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        int          e_lat;
        int          e_iss;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [1:0] op, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rsp, input int rdy, input int dly,
                                 input logic [1:0] e_err, input logic [31:0] e_rdata,
                                 input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                                 input int e_lat, input int e_iss);
        vec_t v;
        v.op = op; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rsp = rsp;
        v.rdy = rdy; v.dly = dly; v.e_err = e_err; v.e_rdata = e_rdata;
        v.e_wdata = e_wdata; v.e_wstrb = e_wstrb; v.e_lat = e_lat; v.e_iss = e_iss;
        return v;
    endfunction

    // Reference model: byte arithmetic on the request, cycle counts from the cache delays.
    function automatic vec_t model(input vec_t vi);
        vec_t   v;
        int     n;
        int     off;
        longint acc;
        v = vi;
        v.e_rdata = '0; v.e_wdata = '0; v.e_wstrb = '0; v.e_iss = 0; v.e_lat = 1;
        off = int'(v.addr[1:0]);
        n   = 1 << v.size;
        if (v.op == BAD || (v.op != FL && v.size == 2'b11)) begin
            v.e_err = 2'b11;
            return v;
        end
        if (v.op != FL && (off % n) != 0) begin
            v.e_err = 2'b01;
            return v;
        end
        v.e_iss = v.rdy + 1;
        if (v.dly < 0) begin
            v.e_err = 2'b10;
            v.e_lat = TO + 1;
        end else begin
            v.e_err = 2'b00;
            v.e_lat = v.rdy + v.dly + 2;
        end
        if (v.op == ST) begin
            for (int i = 0; i < n; i++) begin
                v.e_wdata[8*(off+i) +: 8] = v.wdata[8*i +: 8];
                v.e_wstrb[off+i] = 1'b1;
            end
        end
        if (v.op == LD && v.dly >= 0) begin
            acc = 0;
            for (int i = 0; i < n; i++) acc += longint'(v.rsp[8*(off+i) +: 8]) << (8*i);
            if (!v.uns && acc >= (longint'(1) << (8*n - 1))) acc -= longint'(1) << (8*n);
            v.e_rdata = acc[31:0];
        end
        return v;
    endfunction

    // Starts and ends on a negedge with the DUT idle; plays a cache with the given delays.
    task automatic run_txn(input vec_t v, output logic [31:0] o_rdata, output logic [1:0] o_err,
                           output int o_lat, output int o_iss, output logic [31:0] o_wdata,
                           output logic [3:0] o_wstrb, output logic o_ok);
        int cyc;
        int hs;
        bit done;
        chk("ready_at_start", {31'b0, core_req_ready}, 32'd1);
        core_req_valid = 1'b1; core_req_op = v.op; core_req_size = v.size;
        core_req_unsigned = v.uns; core_req_addr = v.addr; core_req_wdata = v.wdata;
        o_rdata = 'x; o_err = 'x; o_lat = -1; o_iss = 0; o_wdata = '0; o_wstrb = '0; o_ok = 1'b1;
        @(negedge clk);
        core_req_valid = 1'b0;
        core_req_op = 2'($urandom); core_req_size = 2'($urandom);
        core_req_addr = $urandom; core_req_wdata = $urandom; core_req_unsigned = 1'($urandom);
        cyc = 1; hs = -1; done = 0;
        while (!done && cyc < 200) begin
            cache_rsp_valid = (v.dly >= 0 && hs >= 0 && cyc == hs + v.dly);
            cache_rsp_rdata = cache_rsp_valid ? v.rsp : $urandom;
            if (core_rsp_valid) begin
                o_lat = cyc; o_rdata = core_rsp_rdata; o_err = core_rsp_err; done = 1;
            end
            if (cache_req_valid) begin
                if (o_iss == 0) begin
                    o_wdata = cache_req_wdata; o_wstrb = cache_req_wstrb;
                end
                o_ok = o_ok && (cache_req_wdata === o_wdata) && (cache_req_wstrb === o_wstrb)
                       && (cache_req_addr === v.addr) && (cache_req_op === v.op)
                       && (cache_req_size === v.size);
                o_iss++;
                cache_req_ready = (o_iss > v.rdy);
                if (cache_req_ready) hs = cyc;
            end else begin
                cache_req_ready = 1'($urandom);
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        cache_rsp_valid = 1'b0;
        cache_req_ready = 1'b0;
        if (!done) begin
            chk("rsp_within_bound", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            chk("rsp_single_pulse", {31'b0, core_rsp_valid}, 32'd0);
        end
    endtask

    task automatic check_txn(input string tag, input vec_t v);
        logic [31:0] rd, wd;
        logic [1:0]  er;
        logic [3:0]  ws;
        int          lat, iss;
        logic        ok;
        run_txn(v, rd, er, lat, iss, wd, ws, ok);
        chk({tag, ".err"},   {30'b0, er}, {30'b0, v.e_err});
        chk({tag, ".rdata"}, rd, v.e_rdata);
        chk({tag, ".lat"},   lat, v.e_lat);
        chk({tag, ".issue"}, iss, v.e_iss);
        if (v.e_iss > 0) begin
            chk({tag, ".wdata"},  wd, v.e_wdata);
            chk({tag, ".wstrb"},  {28'b0, ws}, {28'b0, v.e_wstrb});
            chk({tag, ".fields"}, {31'b0, ok}, 32'd1);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".ready"},     {31'b0, core_req_ready}, 32'd1);
        chk({tag, ".req_valid"}, {31'b0, cache_req_valid}, 32'd0);
        chk({tag, ".rsp_valid"}, {31'b0, core_rsp_valid}, 32'd0);
        chk({tag, ".rdata"},     core_rsp_rdata, 32'd0);
        chk({tag, ".err"},       {30'b0, core_rsp_err}, 32'd0);
        chk({tag, ".wstrb"},     {28'b0, cache_req_wstrb}, 32'd0);
        chk({tag, ".addr"},      cache_req_addr, 32'd0);
        chk({tag, ".wdata"},     cache_req_wdata, 32'd0);
        chk({tag, ".opsize"},    {28'b0, cache_req_op, cache_req_size}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time bound reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[$];
        vec_t r;
        reset_n = 1'b0; core_req_valid = 1'b0; core_req_op = '0; core_req_size = '0;
        core_req_unsigned = 1'b0; core_req_addr = '0; core_req_wdata = '0;
        cache_req_ready = 1'b0; cache_rsp_valid = 1'b0; cache_rsp_rdata = '0;
        repeat (3) @(negedge clk);
        check_reset("init");
        reset_n = 1'b1;
        @(negedge clk);

        tbl.push_back(mkv(ST, BY, 0, 32'h1003, 32'h123456A5, 32'h0, 0, 1, 2'b00, 0, 32'hA500_0000, 4'b1000, 3, 1));
        tbl.push_back(mkv(LD, HF, 0, 32'h2002, 32'h0, 32'h8001FFFF, 0, 2, 2'b00, 32'hFFFF8001, 0, 0, 4, 1));
        tbl.push_back(mkv(LD, HF, 1, 32'h2002, 32'h0, 32'h8001FFFF, 0, 2, 2'b00, 32'h00008001, 0, 0, 4, 1));
        tbl.push_back(mkv(LD, WD, 0, 32'h3001, 32'h0, 32'h0, 0, 1, 2'b01, 0, 0, 0, 1, 0));
        tbl.push_back(mkv(ST, HF, 0, 32'h0102, 32'h7777BEEF, 32'h0, 2, 1, 2'b00, 0, 32'hBEEF_0000, 4'b1100, 5, 3));
        tbl.push_back(mkv(LD, BY, 0, 32'h0001, 32'h0, 32'h11228033, 0, 1, 2'b00, 32'hFFFFFF80, 0, 0, 3, 1));
        tbl.push_back(mkv(LD, BY, 1, 32'h0003, 32'h0, 32'h9F000000, 1, 3, 2'b00, 32'h0000009F, 0, 0, 6, 2));
        tbl.push_back(mkv(ST, WD, 0, 32'h4000, 32'hDEADBEEF, 32'h0, 0, 2, 2'b00, 0, 32'hDEADBEEF, 4'b1111, 4, 1));
        tbl.push_back(mkv(LD, HF, 0, 32'h2001, 32'h0, 32'h0, 0, 1, 2'b01, 0, 0, 0, 1, 0));
        tbl.push_back(mkv(LD, 2'b11, 0, 32'h0000, 32'h0, 32'h0, 0, 1, 2'b11, 0, 0, 0, 1, 0));
        tbl.push_back(mkv(BAD, WD, 0, 32'h6000, 32'h0, 32'h0, 0, 1, 2'b11, 0, 0, 0, 1, 0));
        tbl.push_back(mkv(LD, WD, 0, 32'h6004, 32'h0, 32'hCAFEF00D, 0, 1, 2'b00, 32'hCAFEF00D, 0, 0, 3, 1));
        tbl.push_back(mkv(FL, HF, 0, 32'h7003, 32'hFFFFFFFF, 32'h5A5A5A5A, 1, 2, 2'b00, 0, 0, 0, 5, 2));
        tbl.push_back(mkv(FL, WD, 0, 32'h5000, 32'h12345678, 32'h0, 5, -1, 2'b10, 0, 0, 0, TO + 1, 6));
        tbl.push_back(mkv(ST, WD, 0, 32'h4002, 32'h0, 32'h0, 0, 1, 2'b01, 0, 0, 0, 1, 0));
        tbl.push_back(mkv(LD, HF, 0, 32'h0000, 32'h0, 32'h12347FFE, 0, 1, 2'b00, 32'h00007FFE, 0, 0, 3, 1));
        foreach (tbl[i]) check_txn($sformatf("vec%0d", i), tbl[i]);

        for (int k = 0; k < 120; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: r.op = ST;
                4, 5, 6, 7: r.op = LD;
                8:          r.op = FL;
                default:    r.op = BAD;
            endcase
            r.size = 2'($urandom_range(0, 3));
            if (r.op == FL && r.size == 2'b11) r.size = WD;
            r.uns   = 1'($urandom);
            r.addr  = $urandom;
            if ($urandom_range(0, 1) == 1) r.addr[1:0] = 2'b00;
            r.wdata = $urandom;
            r.rsp   = $urandom;
            r.rdy   = $urandom_range(0, 3);
            r.dly   = ($urandom_range(0, 24) == 0) ? -1 : int'($urandom_range(1, 6));
            check_txn($sformatf("rnd%0d", k), model(r));
        end

        // Reset while waiting for the cache, then a stray response in IDLE.
        core_req_valid = 1'b1; core_req_op = LD; core_req_size = WD; core_req_unsigned = 1'b0;
        core_req_addr = 32'h12345678; core_req_wdata = $urandom;
        cache_req_ready = 1'b1; cache_rsp_valid = 1'b0;
        @(negedge clk);
        core_req_valid = 1'b0;
        chk("rst.issue_valid", {31'b0, cache_req_valid}, 32'd1);
        chk("rst.issue_addr", cache_req_addr, 32'h12345678);
        @(negedge clk);
        chk("rst.wait_ready", {31'b0, core_req_ready}, 32'd0);
        chk("rst.wait_valid", {31'b0, cache_req_valid}, 32'd0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        reset_n = 1'b1;
        cache_rsp_valid = 1'b1; cache_rsp_rdata = 32'hFEEDFACE;
        @(negedge clk);
        cache_rsp_valid = 1'b0;
        chk("rst.stray1", {31'b0, core_rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rst.stray2", {31'b0, core_rsp_valid}, 32'd0);
        chk("rst.idle_ready", {31'b0, core_req_ready}, 32'd1);
        check_txn("post_rst", mkv(LD, BY, 1, 32'h0102, 32'h0, 32'hAABBCCDD, 0, 1, 2'b00, 32'h000000BB, 0, 0, 3, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
